// File: rtl/aes_xd.sv
// aes_xd: export-build AES stand-in with a real core's handshake and latency.
// It applies a key-derived XOR with optional block chaining and no cryptography.
module aes_xd #(
  parameter int DW  = 32,
  parameter int LAT = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          go,
  input  logic [1:0]    ksize,
  input  logic          mode,
  input  logic [DW-1:0] key,
  input  logic          key_vld,
  output logic          key_req,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_req,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          busy
);

  localparam int NW  = 128 / DW;
  localparam int NKX = 256 / DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
    S_CALC,
    S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [255:0]  r_kr;
  logic [127:0]  r_cr;
  logic [127:0]  r_din;
  logic [127:0]  r_obuf;
  logic [DW-1:0] r_dout;
  logic [2:0]    r_widx;
  logic [2:0]    r_nkm1;
  logic [7:0]    r_lat;
  logic          r_mode;

  logic          w_hs;
  logic          w_ktx;
  logic          w_dtx;
  logic          w_otx;
  logic          w_klast;
  logic          w_dlast;
  logic          w_olast;
  logic [2:0]    w_nkm1;
  logic [2:0]    w_nidx;
  logic [255:0]  w_kr_nxt;
  logic [127:0]  w_din_nxt;
  logic [127:0]  w_ek;
  logic [127:0]  w_res;
  logic [DW-1:0] w_onext;

  // A go cycle owns the block: no word may transfer while it restarts.
  assign w_hs     = en & ~go;
  assign key_req  = w_hs & (r_state == S_KEY);
  assign din_req  = w_hs & (r_state == S_DATA);
  assign dout_vld = w_hs & (r_state == S_OUT);
  assign busy     = (r_state != S_IDLE);
  assign dout     = r_dout;

  assign w_ktx   = key_req & key_vld;
  assign w_dtx   = din_req & din_vld;
  assign w_otx   = dout_vld & dout_rdy;
  assign w_klast = (r_widx == r_nkm1);
  assign w_dlast = (r_widx == 3'(NW - 1));
  assign w_olast = (r_widx == 3'(NW - 1));
  assign w_nidx  = r_widx + 3'd1;

  assign w_ek  = r_kr[127:0] ^ r_kr[255:128];
  assign w_res = r_din ^ w_ek ^ (r_mode ? r_cr : 128'd0);

  always_comb begin
    case (ksize)
      2'd1:    w_nkm1 = 3'(192 / DW - 1);
      2'd2:    w_nkm1 = 3'(NKX - 1);
      default: w_nkm1 = 3'(NW - 1);
    endcase
  end

  always_comb begin
    w_kr_nxt = r_kr;
    for (int j = 0; j < NKX; j++) begin
      if (r_widx == 3'(j)) w_kr_nxt[j*DW +: DW] = key;
    end
  end

  always_comb begin
    w_din_nxt = r_din;
    for (int j = 0; j < NW; j++) begin
      if (r_widx == 3'(j)) w_din_nxt[j*DW +: DW] = din;
    end
  end

  always_comb begin
    w_onext = '0;
    for (int j = 0; j < NW; j++) begin
      if (w_nidx == 3'(j)) w_onext = r_obuf[j*DW +: DW];
    end
  end

  always_comb begin
    w_nxt = r_state;
    if (!en) begin
      w_nxt = S_IDLE;
    end else if (go) begin
      w_nxt = S_KEY;
    end else begin
      unique case (r_state)
        S_KEY:   if (w_ktx && w_klast) w_nxt = S_DATA;
        S_DATA:  if (w_dtx && w_dlast) w_nxt = S_CALC;
        S_CALC:  if (r_lat == 8'd0) w_nxt = S_OUT;
        S_OUT:   if (w_otx && w_olast) w_nxt = S_DATA;
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kr   <= '0;
      r_cr   <= '0;
      r_din  <= '0;
      r_obuf <= '0;
      r_dout <= '0;
      r_widx <= '0;
      r_nkm1 <= '0;
      r_lat  <= '0;
      r_mode <= 1'b0;
    end else if (en && go) begin
      r_kr   <= '0;
      r_cr   <= '0;
      r_din  <= '0;
      r_widx <= '0;
      r_lat  <= '0;
      r_nkm1 <= w_nkm1;
      r_mode <= mode;
    end else if (!en) begin
      // KR and CR survive; only the in-flight block position is dropped.
      r_widx <= '0;
      r_lat  <= '0;
    end else begin
      if (w_ktx) begin
        r_kr   <= w_kr_nxt;
        r_widx <= w_klast ? 3'd0 : w_nidx;
      end
      if (w_dtx) begin
        r_din  <= w_din_nxt;
        r_widx <= w_dlast ? 3'd0 : w_nidx;
        if (w_dlast) r_lat <= 8'(LAT - 1);
      end
      if (r_state == S_CALC) begin
        if (r_lat == 8'd0) begin
          r_obuf <= w_res;
          r_cr   <= w_res;
          r_dout <= w_res[DW-1:0];
        end else begin
          r_lat <= r_lat - 8'd1;
        end
      end
      if (w_otx) begin
        if (w_olast) begin
          r_widx <= 3'd0;
        end else begin
          r_widx <= w_nidx;
          r_dout <= w_onext;
        end
      end
    end
  end

endmodule
